// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq: sequential AES SubBytes engine for the 128-bit state.
//
// A 128-bit block is accepted, and its 16 bytes are substituted LANES at a
// time. Each block takes N = 16/LANES cycles, starting with byte 0 (bits
// [127:120]) and working toward byte 15. The result is returned over a
// valid/ready handshake.
//
// Optional feature: define SUB_BYTES_INV_EN to build the inverse S-box lanes.
// When it is defined, in_inv selects inverse substitution. When it is not
// defined, the engine is forward-only and in_inv is ignored.
//
// Handshake rules:
//   - An input block is taken on a rising edge where in_valid && in_ready.
//   - A result is taken on a rising edge where out_valid && out_ready.
//   - out_valid/out_data stay stable until taken.
//   - Inputs are never stored while in_ready is low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input block valid
//   in_ready   engine idle, can accept a block
//   in_data    128-bit state block, byte 0 = [127:120]
//   in_inv     1 = inverse S-box, 0 = forward (sampled with the block)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   substituted block, same byte order as in_data
//   busy       high while a block is in flight (BUSY or DONE)
//
// Also in this file:
//   sub_bytes_pkg  GF(2^8) helper functions
//   mem            forward S-box, one per lane
//   inv_mem        inverse S-box, one per lane, only with SUB_BYTES_INV_EN
// -----------------------------------------------------------------------------

package sub_bytes_pkg;

  // Multiply in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse, computed as a^254. This maps 0 to 0, which is
  // what the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

endpackage

// Forward S-box lookup, purely combinational.
module mem (
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);
  assign data_o = sub_bytes_pkg::sbox_fwd(addr_i);
endmodule

`ifdef SUB_BYTES_INV_EN
// Inverse S-box lookup, purely combinational.
module inv_mem (
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);
  assign data_o = sub_bytes_pkg::sbox_inv(addr_i);
endmodule
`endif

module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [127:0]   work_q, work_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_fwd [LANES];
  logic [7:0] lane_out [LANES];

`ifdef SUB_BYTES_INV_EN
  logic       mode_q, mode_d;
  logic [7:0] lane_inv [LANES];
`else
  // Forward-only build: the mode is effectively fixed at 0 and in_inv has
  // no effect.
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
`endif

  // Lane L works on byte cnt*LANES+L. Byte k sits at bits [8*(15-k) +: 8].
  always_comb begin : lane_select
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[8*(15 - (int'(cnt_q) * LANES + l)) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mem u_fwd (.addr_i(lane_in[l]), .data_o(lane_fwd[l]));
`ifdef SUB_BYTES_INV_EN
    inv_mem u_inv (.addr_i(lane_in[l]), .data_o(lane_inv[l]));
    // The lane mux uses the registered mode, so in_inv changing during BUSY
    // has no effect on the block in flight.
    assign lane_out[l] = mode_q ? lane_inv[l] : lane_fwd[l];
`else
    assign lane_out[l] = lane_fwd[l];
`endif
  end

  always_comb begin : next_state
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
`ifdef SUB_BYTES_INV_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
`ifdef SUB_BYTES_INV_EN
          mode_d  = in_inv;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[8*(15 - (int'(cnt_q) * LANES + l)) +: 8] = lane_out[l];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          // Clear explicitly: with N=1 the 1-bit counter would not wrap to 0.
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // in_valid is ignored here. The engine re-arms only through IDLE.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
`ifdef SUB_BYTES_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
`ifdef SUB_BYTES_INV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // All outputs are decoded straight from registers.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_seq: instantiates sub_bytes_seq for LANES = 1, 2, 4, 8 and 16.
//
// Each instance has its own driver and monitor. The driver pushes the
// expected block and its accept cycle into queues. The monitor pops and
// compares whenever out_valid is high.
//
// The expected results come from S-box tables that are built by brute-force
// inverse search and the bitwise FIPS-197 affine formula.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];
  bit tables_ok = 1'b0;

`ifdef SUB_BYTES_INV_EN
  localparam logic [127:0] EXP_INV63 = '0;
  localparam logic [127:0] EXP_INVED = {16{8'h53}};
`else
  localparam logic [127:0] EXP_INV63 = {16{8'hfb}};
  localparam logic [127:0] EXP_INVED = {16{8'h55}};
`endif
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (a[i]) prod ^= (16'(b) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod ^= (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] d, input bit inv);
    logic [127:0] r;
    logic [7:0]   b;
    bit           use_inv;
`ifdef SUB_BYTES_INV_EN
    use_inv = inv;
`else
    use_inv = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      b = d[8*(15-i) +: 8];
      r[8*(15-i) +: 8] = use_inv ? isb[b] : sb[b];
    end
    return r;
  endfunction

  task automatic chk(input string name, input int lanes, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lanes=%0d: got %h expected %h", name, lanes, act, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int L = 1 << g;
    localparam int N = 16 / L;

    logic         rst_n, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic [127:0] exp_q[$];
    int unsigned  acc_q[$];
    bit           mon_en, rnd_ready, done_g;
    int           stall;

    sub_bytes_seq #(.LANES(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    task automatic send(input logic [127:0] d, input bit inv, input logic [127:0] exp,
                        input bit rnd);
      int budget = 0;
      in_data  = d;
      in_inv   = inv;
      in_valid = 1'b1;
      while (1) begin
        if (rnd) in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid && in_ready) break;
        @(negedge clk);
        budget++;
        if (budget > 300) begin
          n_cmp++; n_err++;
          $display("FAIL accept_timeout lanes=%0d: got no accept expected accept within 300 cycles", L);
          in_valid = 1'b0;
          return;
        end
      end
      exp_q.push_back(exp);
      acc_q.push_back(cyc + 1);
      @(negedge clk);
      in_valid = 1'b0;
      if (rnd) begin
        // Scramble inputs during BUSY: they must not affect the block in flight.
        in_inv  = 1'($urandom_range(0, 1));
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
    endtask

    task automatic drain();
      int budget = 0;
      while (exp_q.size() != 0 && budget < 2000) begin
        @(negedge clk);
        budget++;
      end
      if (exp_q.size() != 0) begin
        n_cmp++; n_err++;
        $display("FAIL drain_timeout lanes=%0d: got %0d pending expected 0", L, exp_q.size());
      end
    endtask

    // Driver
    initial begin
      logic [127:0] d;
      bit           inv;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
      mon_en = 1'b1; rnd_ready = 1'b0; stall = 0; done_g = 1'b0;
      wait (tables_ok);
      repeat (2) @(negedge clk);
      chk("reset_in_ready", L, 128'(in_ready), 128'(1'b1));
      chk("reset_out_valid", L, 128'(out_valid), 128'(1'b0));
      chk("reset_out_data", L, out_data, '0);
      chk("reset_busy", L, 128'(busy), 128'(1'b0));
      rst_n = 1'b1;

      send('0, 1'b0, {16{8'h63}}, 1'b0);
      send(FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
      send({16{8'h63}}, 1'b1, EXP_INV63, 1'b0);
      send({16{8'hed}}, 1'b1, EXP_INVED, 1'b0);

      // Backpressure: one block is held in DONE for 10 cycles while the next
      // block is already being offered.
      stall = 10;
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b0, ref_block(d, 1'b0), 1'b0);
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b1, ref_block(d, 1'b1), 1'b0);
      drain();

      // Reset three cycles into a block: nothing may come out of it.
      mon_en = 1'b0;
      @(negedge clk);
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b0, ref_block(d, 1'b0), 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_in_ready", L, 128'(in_ready), 128'(1'b1));
      chk("midreset_out_valid", L, 128'(out_valid), 128'(1'b0));
      chk("midreset_busy", L, 128'(busy), 128'(1'b0));
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      send(FIPS_IN, 1'b0, FIPS_OUT, 1'b0);

      // Random blocks, back to back, with random out_ready.
      rnd_ready = 1'b1;
      repeat (100) begin
        d   = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        send(d, inv, ref_block(d, inv), 1'b1);
        if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();
      done_g = 1'b1;
    end

    // Monitor
    initial begin
      bit seen = 1'b0;
      bit rel  = 1'b0;
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (!mon_en || !rst_n) begin
          out_ready = 1'b0; seen = 1'b0; rel = 1'b0;
          continue;
        end
        if (rel) begin
          chk("in_ready_after_release", L, 128'(in_ready), 128'(1'b1));
          chk("out_valid_after_release", L, 128'(out_valid), 128'(1'b0));
          rel = 1'b0;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_output lanes=%0d: got %h expected no output", L, out_data);
            out_ready = 1'b1;
          end else begin
            chk("out_data", L, out_data, exp_q[0]);
            chk("in_ready_in_done", L, 128'(in_ready), 128'(1'b0));
            chk("busy_in_done", L, 128'(busy), 128'(1'b1));
            if (!seen) chk("latency", L, 128'(cyc - acc_q[0]), 128'(N));
            seen = 1'b1;
            if (stall > 0) begin
              stall--;
              out_ready = 1'b0;
            end else begin
              out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen = 1'b0;
              rel  = 1'b1;
            end
          end
        end else begin
          out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  // Table build and overall termination.
  initial begin
    logic [7:0] c;
    logic [7:0] b;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = '0;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
    tables_ok = 1'b1;
    for (int t = 0; t < 40000; t++) begin
      @(negedge clk);
      if (g_dut[0].done_g && g_dut[1].done_g && g_dut[2].done_g &&
          g_dut[3].done_g && g_dut[4].done_g) break;
    end
    if (!(g_dut[0].done_g && g_dut[1].done_g && g_dut[2].done_g &&
          g_dut[3].done_g && g_dut[4].done_g)) begin
      n_cmp++; n_err++;
      $display("FAIL global_timeout: got unfinished drivers expected all done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
